// File: rtl/request_encoder.sv
// request_encoder: latches request pulses into a pending vector and hands out
// one pending index at a time on a valid/ready port, clearing each bit when it
// is consumed. The default build uses fixed lowest-index priority.
// Optional macro REQUEST_ENCODER_ROUND_ROBIN_EN replaces it with a rotating
// search that starts just after the last granted index.
module request_encoder #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_index,
    output logic [N-1:0]         pending,
    output logic                 coalesced
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] IDX_ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state_reg;
    logic [N-1:0]   pending_reg;
    logic [N-1:0]   pending_next;
    logic           coalesced_reg;
    logic           out_valid_reg;
    logic [W-1:0]   out_index_reg;
    logic [N-1:0]   set_vec;
    logic [N-1:0]   clr_vec;
    logic           handshake;
    logic [W-1:0]   scan_base;
    logic [W-1:0]   scan_idx;
    logic [W-1:0]   sel_index;
    logic           sel_found;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0]   ptr_reg;
    assign scan_base = ptr_reg;
`else
    assign scan_base = '0;
`endif

    assign handshake = out_valid_reg && out_ready;
    assign set_vec   = en ? req : '0;

    // One-hot clear of the presented index, only on a handshake edge
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign clr_vec[gi] = handshake && (out_index_reg == W'(gi));
        end
    endgenerate

    // Set has priority over clear so a same-edge re-request is not lost
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;

    // First set bit of the registered pending, scanning upward from scan_base with wrap
    always_comb begin
        sel_index = '0;
        sel_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = scan_base + k[W-1:0];
            if (!sel_found && pending_reg[scan_idx]) begin
                sel_index = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    // Pending vector and coalesce pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg   <= '0;
            coalesced_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            coalesced_reg <= |(set_vec & pending_reg & ~clr_vec);
        end
    end

    // Grant FSM: load an index from IDLE, hold it in PRESENT until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
            ptr_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pending_reg != '0) begin
                        out_index_reg <= sel_index;
                        out_valid_reg <= 1'b1;
                        state_reg     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
                        ptr_reg       <= out_index_reg + IDX_ONE;
`endif
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifndef REQUEST_ENCODER_ROUND_ROBIN_EN
    // IDX_ONE only feeds the pointer; keep it referenced in the fixed build
    logic unused_one;
    assign unused_one = ^IDX_ONE;
`endif

    assign out_valid = out_valid_reg;
    assign out_index = out_index_reg;
    assign pending   = pending_reg;
    assign coalesced = coalesced_reg;

endmodule

// File: tb/tb_request_encoder.sv
// Testbench for request_encoder: directed scenarios plus random traffic,
// checked by a transaction-level model and a grant scoreboard.
module tb_request_encoder;

    localparam int N = 32;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [N-1:0] req = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic [N-1:0] pending;
    logic         coalesced;

    int checks = 0;
    int errors = 0;

    // model state: set of outstanding requests, current grant, next search start
    logic [N-1:0] mpend = '0;
    logic         mvalid = 1'b0;
    int           midx = 0;
    int           mptr = 0;
    logic         mcoal = 1'b0;
    int           expq[$];

    request_encoder #(.N(N)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(out_valid), .out_index(out_index), .pending(pending),
        .coalesced(coalesced)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // first outstanding request at or after start, wrapping around
    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    // apply inputs for one cycle, advance the model, compare after the edge
    task automatic step(input logic e, input logic [N-1:0] r, input logic rdy);
        logic [N-1:0] s;
        logic [N-1:0] c;
        en = e; req = r; out_ready = rdy;
        s = e ? r : '0;
        c = '0;
        if (mvalid && rdy) c[midx] = 1'b1;
        mcoal = |(s & mpend & ~c);
        if (mvalid) begin
            if (rdy) begin
                mvalid = 1'b0;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
                mptr = (midx + 1) % N;
`endif
            end
        end else if (mpend != '0) begin
            midx = pick(mpend, mptr);
            mvalid = 1'b1;
            expq.push_back(midx);
        end
        mpend = (mpend & ~c) | s;
        @(posedge clk);
        #1;
        check("pending", pending, mpend);
        check("coalesced", N'(coalesced), N'(mcoal));
        check("out_valid", N'(out_valid), N'(mvalid));
        if (mvalid) check("out_index_hold", N'(out_index), N'(midx));
    endtask

    task automatic model_reset();
        mpend = '0; mvalid = 1'b0; midx = 0; mptr = 0; mcoal = 1'b0;
        expq.delete();
    endtask

    initial begin
        // scoreboard monitor: every accepted grant must match the queued expectation
        fork
            forever begin
                int e;
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant: got %0d expected none at %0t", out_index, $time);
                    end else begin
                        e = expq.pop_front();
                        check("grant", N'(out_index), N'(e));
                        $display("grant index %0d at %0t", out_index, $time);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_pending", pending, '0);
        check("reset_valid", N'(out_valid), '0);
        reset = 1'b0;

        // single request: index 4 presented after two edges, gone after three
        step(1'b1, 32'h0000_0010, 1'b1);
        check("single_pending", pending, 32'h10);
        step(1'b0, '0, 1'b1);
        check("single_index", N'(out_index), 32'd4);
        step(1'b0, '0, 1'b1);
        check("single_done", pending | N'(out_valid), '0);

        // multi-request pulse
        step(1'b1, 32'h8000_0005, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // backpressure with an extra lower request arriving mid-hold
        step(1'b1, 32'h0000_0006, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0001, 1'b0);
        repeat (6) step(1'b0, '0, 1'b0);
        repeat (8) step(1'b0, '0, 1'b1);

        // re-request on the handshake edge of index 3
        step(1'b1, 32'h0000_0008, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0008, 1'b1);
        check("rearm_pending", pending, 32'h8);
        repeat (4) step(1'b0, '0, 1'b1);

        // coalesce: hold index 1 so index 5 stays unserved, then pulse 5 twice
        step(1'b1, 32'h0000_0022, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0020, 1'b0);
        check("coalesce_pulse", N'(coalesced), 32'd1);
        step(1'b0, '0, 1'b0);
        check("coalesce_clear", N'(coalesced), 32'd0);
        // capture disabled: all-ones request must be ignored
        step(1'b0, 32'hFFFF_FFFF, 1'b0);
        check("en_off", pending, 32'h22);
        repeat (6) step(1'b0, '0, 1'b1);

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        // held requests rotate through 0..3
        repeat (12) step(1'b1, 32'h0000_000F, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1);
        // drive the pointer to 31 and check wrap to 0
        repeat (70) step(1'b1, 32'h8000_0001, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), N'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 2) != 0));
        end

        // drain with a bounded budget
        for (int i = 0; i < 200 && (mpend != '0 || mvalid); i++) step(1'b0, '0, 1'b1);
        check("drain_done", N'(mvalid) | mpend, '0);
        check("queue_empty", N'(expq.size()), '0);

        // asynchronous reset mid-grant with pending = 0x3
        step(1'b1, 32'h0000_0003, 1'b0);
        step(1'b0, '0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("areset_valid", N'(out_valid), '0);
        check("areset_index", N'(out_index), '0);
        check("areset_pending", pending, '0);
        check("areset_coal", N'(coalesced), '0);
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check("post_reset_queue", N'(expq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
